alu_acc_core: RTL

Parametrised, handshaked successor to the team's 8-bit accumulator ALU. Operand width is configurable, and the block uses valid/ready flow control on input and output. Division is an iterative multi-cycle operation; rotates are by a variable amount; result flags are reported with each result. It sits between an operand sequencer and a result consumer, and the accumulator persists across operations.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_acc_core_if.sv | 27 ++
 rtl/alu_div.sv | 60 ++++++
 rtl/alu_acc_core.sv | 135 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the handshaked accumulator ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV,
        OP_ADDA, OP_MULA, OP_MAC,
        OP_ROL, OP_ROR,
        OP_AND, OP_OR, OP_XOR, OP_NAND,
        OP_EQ, OP_GT, OP_LT
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_HOLD
    } state_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_DZ    = 2;
    localparam int FLAG_W     = 3;

endpackage

// File: rtl/alu_acc_core_if.sv
// Request/response bundle between the operand sequencer (master) and the ALU core (slave).
interface alu_acc_core_if #(parameter int WIDTH = 8);
    import alu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    op_e                op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               acc_clr;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [FLAG_W-1:0]  flags;
    logic [WIDTH-1:0]   acc;

    modport master (
        output in_valid, op, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, result, flags, acc
    );

    modport slave (
        input  in_valid, op, a, b, acc_clr, out_ready,
        output in_ready, out_valid, result, flags, acc
    );

endinterface

// File: rtl/alu_div.sv
// Restoring unsigned divider, one quotient bit per cycle; done/quotient are valid in the final iteration cycle.
module alu_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d, quo_d;

    // Top bit of the trial difference is the restore decision.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done) busy_q <= 1'b0;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign quotient = quo_d;

endmodule

// File: rtl/alu_acc_core.sv
// Handshaked accumulator ALU: single-cycle op datapath, iterative divider, output register and accumulator.
module alu_acc_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_acc_core_if.slave bus
);

    localparam int SH_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q, acc_q;
    logic [FLAG_W-1:0]  flags_q;
    logic               in_ready;

    logic               accept, div_start, fast_done, complete;
    logic               div_busy, div_done;
    logic [WIDTH-1:0]   div_quo;

    logic [WIDTH-1:0]   res, cres;
    logic               carry;
    logic [FLAG_W-1:0]  cflags;
    logic [WIDTH:0]     sum_ab, dif_ab, sum_acc_a, sum_mac;
    logic [WIDTH-1:0]   mul_ab, mul_acc;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [SH_W-1:0]    sh;

    assign accept    = bus.in_valid && in_ready;
    assign div_start = accept && (bus.op == OP_DIV) && (bus.b != '0);
    assign fast_done = accept && !div_start;
    assign complete  = fast_done || div_done;

    alu_div #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (bus.a),
        .divisor  (bus.b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_comb begin
        sh        = bus.b[SH_W-1:0];
        mul_ab    = bus.a * bus.b;
        mul_acc   = acc_q * bus.a;
        sum_ab    = {1'b0, bus.a} + {1'b0, bus.b};
        dif_ab    = {1'b0, bus.a} - {1'b0, bus.b};
        sum_acc_a = {1'b0, acc_q} + {1'b0, bus.a};
        sum_mac   = {1'b0, acc_q} + {1'b0, mul_ab};
        rot_l     = {bus.a, bus.a} << sh;
        rot_r     = {bus.a, bus.a} >> sh;
        res       = '0;
        carry     = 1'b0;
        case (bus.op)
            OP_ADD:  begin res = sum_ab[WIDTH-1:0];    carry = sum_ab[WIDTH];    end
            OP_SUB:  begin res = dif_ab[WIDTH-1:0];    carry = dif_ab[WIDTH];    end
            OP_MUL:  res = mul_ab;
            OP_DIV:  res = '1;  // only reaches the output on divide-by-zero
            OP_ADDA: begin res = sum_acc_a[WIDTH-1:0]; carry = sum_acc_a[WIDTH]; end
            OP_MULA: res = mul_acc;
            OP_MAC:  begin res = sum_mac[WIDTH-1:0];   carry = sum_mac[WIDTH];   end
            OP_ROL:  res = rot_l[2*WIDTH-1:WIDTH];
            OP_ROR:  res = rot_r[WIDTH-1:0];
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_XOR:  res = bus.a ^ bus.b;
            OP_NAND: res = ~(bus.a & bus.b);
            OP_EQ:   res = {WIDTH{bus.a == bus.b}};
            OP_GT:   res = {WIDTH{bus.a > bus.b}};
            OP_LT:   res = {WIDTH{bus.a < bus.b}};
            default: res = '0;
        endcase
    end

    // Divider completion takes priority; no new op can be accepted while it runs.
    always_comb begin
        cres   = div_done ? div_quo : res;
        cflags = '0;
        cflags[FLAG_ZERO]  = (cres == '0);
        cflags[FLAG_CARRY] = !div_done && carry;
        cflags[FLAG_DZ]    = !div_done && (bus.op == OP_DIV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (div_start)                          state_d = ST_DIV;
                else if (fast_done && !bus.out_ready)   state_d = ST_HOLD;
            end
            ST_DIV:  if (div_done)      state_d = ST_HOLD;
            ST_HOLD: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid_q;
        bus.result    = result_q;
        bus.flags     = flags_q;
        bus.acc       = acc_q;
    end

    // A completing result overrides a same-edge acc_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
        end else if (complete) begin
            out_valid_q <= 1'b1;
            result_q    <= cres;
            flags_q     <= cflags;
            acc_q       <= cres;
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            if (bus.acc_clr)                  acc_q       <= '0;
        end
    end

endmodule
